// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX register stage that decodes ALUOp/funct into the ALU code and issues operands
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   valid_in, stall, flush      instruction-valid qualifier and hazard-unit hold/bubble controls
//   ALUOp, funct3, funct7_5     main-control class and funct fields feeding the ALU decode
//   rs1_data, rs2_data, imm     64-bit register reads and sign-extended immediate
//   alu_src                     selects imm instead of rs2_data as operand B
//   rd_in, *_in control bits    destination index and EX/MEM/WB controls carried forward
//   a, b, alu_ctrl, store_data  registered ALU operands, ALU code and store data
//   rd_out, control bits        registered destination and controls
//   valid_out, illegal          stage holds a real instruction / decode hit an unsupported funct
module id_ex_alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  ALUOp,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic        alu_src,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        branch_in,
  input  logic        mem_to_reg_in,
  output logic [63:0] a,
  output logic [63:0] b,
  output logic [3:0]  alu_ctrl,
  output logic [63:0] store_data,
  output logic [4:0]  rd_out,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        mem_to_reg,
  output logic        valid_out,
  output logic        illegal
);
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0100;
  logic [63:0] r_a, r_b, r_store_data;
  logic [3:0]  r_alu_ctrl;
  logic [4:0]  r_rd;
  logic        r_reg_write, r_mem_read, r_mem_write, r_branch, r_mem_to_reg, r_valid, r_illegal;
  logic [3:0]  w_code;
  logic        w_illegal;
  logic [3:0]  w_rkey;
  logic        w_bubble;
  assign w_rkey = {funct7_5, funct3};
  // R-type uses funct7_5 to split ADD/SUB; I-type ignores it, so SUB is never legal there.
  always_comb begin
    w_code    = ALU_ADD;
    w_illegal = 1'b0;
    case (ALUOp)
      2'b00: w_code = ALU_ADD;
      2'b01: w_code = ALU_SUB;
      2'b10: case (w_rkey)
        4'b0000: w_code = ALU_ADD;
        4'b1000: w_code = ALU_SUB;
        4'b0111: w_code = ALU_AND;
        4'b0110: w_code = ALU_OR;
        4'b0010: w_code = ALU_LT;
        default: w_illegal = 1'b1;
      endcase
      default: case (funct3)
        3'b000:  w_code = ALU_ADD;
        3'b111:  w_code = ALU_AND;
        3'b110:  w_code = ALU_OR;
        3'b010:  w_code = ALU_LT;
        default: w_illegal = 1'b1;
      endcase
    endcase
  end
  // Flush beats stall; a non-stalled load of a non-valid slot is also a bubble.
  assign w_bubble = flush || (!stall && !valid_in);
  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_alu_ctrl   <= ALU_ADD;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_a          <= rs1_data;
      r_b          <= alu_src ? imm : rs2_data;
      r_store_data <= rs2_data;
      r_alu_ctrl   <= w_code;
      r_rd         <= rd_in;
      r_reg_write  <= reg_write_in;
      r_mem_read   <= mem_read_in;
      r_mem_write  <= mem_write_in;
      r_branch     <= branch_in;
      r_mem_to_reg <= mem_to_reg_in;
      r_valid      <= 1'b1;
      r_illegal    <= w_illegal;
    end
  end
  assign a          = r_a;
  assign b          = r_b;
  assign store_data = r_store_data;
  assign alu_ctrl   = r_alu_ctrl;
  assign rd_out     = r_rd;
  assign reg_write  = r_reg_write;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign branch     = r_branch;
  assign mem_to_reg = r_mem_to_reg;
  assign valid_out  = r_valid;
  assign illegal    = r_illegal;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: directed plus random checks of id_ex_alu_issue against a table-driven reference model
module tb_id_ex_alu_issue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, valid_in, stall, flush, funct7_5, alu_src;
  logic        reg_write_in, mem_read_in, mem_write_in, branch_in, mem_to_reg_in;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [63:0] rs1_data, rs2_data, imm;
  logic [4:0]  rd_in;
  logic [63:0] a, b, store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd_out;
  logic        reg_write, mem_read, mem_write, branch, mem_to_reg, valid_out, illegal;
  id_ex_alu_issue dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .branch_in(branch_in), .mem_to_reg_in(mem_to_reg_in),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .store_data(store_data), .rd_out(rd_out),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .mem_to_reg(mem_to_reg), .valid_out(valid_out), .illegal(illegal)
  );
  typedef struct {
    logic [63:0] a, b, sd;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, m2r, v, ill;
  } st_t;
  st_t m;
  int errors = 0;
  int checks = 0;
  int rtab[int];
  int itab[int];
  function automatic st_t bubble();
    st_t s;
    s = '{a: 64'd0, b: 64'd0, sd: 64'd0, alu: 4'b0010, rd: 5'd0,
          rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, m2r: 1'b0, v: 1'b0, ill: 1'b0};
    return s;
  endfunction
  function automatic st_t predict();
    st_t s;
    int key;
    if (reset || flush) return bubble();
    if (stall) return m;
    if (!valid_in) return bubble();
    s = bubble();
    s.a = rs1_data;
    s.b = alu_src ? imm : rs2_data;
    s.sd = rs2_data;
    s.rd = rd_in;
    {s.rw, s.mr, s.mw, s.br, s.m2r} = {reg_write_in, mem_read_in, mem_write_in, branch_in, mem_to_reg_in};
    s.v = 1'b1;
    if (ALUOp == 2'd0) s.alu = 4'b0010;
    else if (ALUOp == 2'd1) s.alu = 4'b0110;
    else if (ALUOp == 2'd2) begin
      key = int'({funct7_5, funct3});
      if (rtab.exists(key)) s.alu = 4'(rtab[key]); else s.ill = 1'b1;
    end else begin
      key = int'(funct3);
      if (itab.exists(key)) s.alu = 4'(itab[key]); else s.ill = 1'b1;
    end
    return s;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic chk_all();
    chk("a", a, m.a);
    chk("b", b, m.b);
    chk("store_data", store_data, m.sd);
    chk("alu_ctrl", 64'(alu_ctrl), 64'(m.alu));
    chk("rd_out", 64'(rd_out), 64'(m.rd));
    chk("ctrl", 64'({reg_write, mem_read, mem_write, branch, mem_to_reg}), 64'({m.rw, m.mr, m.mw, m.br, m.m2r}));
    chk("valid_out", 64'(valid_out), 64'(m.v));
    chk("illegal", 64'(illegal), 64'(m.ill));
  endtask
  task automatic tick();
    st_t n;
    n = predict();
    @(posedge clk);
    #1;
    m = n;
    chk_all();
  endtask
  task automatic rnd();
    valid_in = 1'($urandom);
    ALUOp = 2'($urandom);
    funct3 = 3'($urandom);
    funct7_5 = 1'($urandom);
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
    imm = {$urandom, $urandom};
    alu_src = 1'($urandom);
    rd_in = 5'($urandom);
    {reg_write_in, mem_read_in, mem_write_in, branch_in, mem_to_reg_in} = 5'($urandom);
  endtask
  logic [3:0] rkeys [5] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0010};
  logic [3:0] rcodes [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100};
  initial begin
    rtab[0] = 2; rtab[8] = 6; rtab[7] = 0; rtab[6] = 1; rtab[2] = 4;
    itab[0] = 2; itab[7] = 0; itab[6] = 1; itab[2] = 4;
    m = bubble();
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    rnd();
    tick();
    rnd();
    tick();
    chk("reset_alu", 64'(alu_ctrl), 64'h2);
    chk("reset_valid", 64'(valid_out), 64'h0);
    chk("reset_a", a, 64'h0);
    reset = 1'b0;
    rnd();
    valid_in = 1'b1;
    ALUOp = 2'b10;
    rs1_data = 64'hF0;
    rs2_data = 64'h0F;
    alu_src = 1'b0;
    for (int i = 0; i < 5; i++) begin
      {funct7_5, funct3} = rkeys[i];
      tick();
      chk("rtype_alu", 64'(alu_ctrl), 64'(rcodes[i]));
      chk("rtype_b", b, 64'h0F);
      chk("rtype_ill", 64'(illegal), 64'h0);
    end
    {funct7_5, funct3} = 4'b0100;
    tick();
    chk("rtype_bad_alu", 64'(alu_ctrl), 64'h2);
    chk("rtype_bad_ill", 64'(illegal), 64'h1);
    ALUOp = 2'b11;
    funct3 = 3'b000;
    funct7_5 = 1'b1;
    imm = 64'hFFFFFFFFFFFFFFF8;
    alu_src = 1'b1;
    tick();
    chk("itype_alu", 64'(alu_ctrl), 64'h2);
    chk("itype_b", b, 64'hFFFFFFFFFFFFFFF8);
    chk("itype_ill", 64'(illegal), 64'h0);
    ALUOp = 2'b00;
    mem_read_in = 1'b1;
    tick();
    chk("load_alu", 64'(alu_ctrl), 64'h2);
    chk("load_mr", 64'(mem_read), 64'h1);
    ALUOp = 2'b01;
    rs1_data = 64'd5;
    tick();
    chk("branch_alu", 64'(alu_ctrl), 64'h6);
    chk("branch_a", a, 64'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd();
      valid_in = 1'b1;
      ALUOp = 2'b10;
      {funct7_5, funct3} = 4'b0111;
      tick();
      chk("stall_alu", 64'(alu_ctrl), 64'h6);
      chk("stall_a", a, 64'd5);
    end
    stall = 1'b0;
    tick();
    chk("release_alu", 64'(alu_ctrl), 64'h0);
    ALUOp = 2'b00;
    mem_write_in = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_valid", 64'(valid_out), 64'h0);
    chk("flush_mw", 64'(mem_write), 64'h0);
    chk("flush_alu", 64'(alu_ctrl), 64'h2);
    stall = 1'b0;
    flush = 1'b0;
    valid_in = 1'b0;
    reg_write_in = 1'b1;
    tick();
    chk("novalid_rw", 64'(reg_write), 64'h0);
    for (int i = 0; i < 500; i++) begin
      rnd();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 31) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

ID/EX pipeline stage that feeds the 64-bit ALU. It decodes the main-control ALUOp plus funct3/funct7[5] into the ALU's 4-bit operation code and selects operand B (register or immediate). It registers operands, ALU code and EX/MEM/WB control bits, with stall (hold) and flush (bubble) support for the hazard unit. It is the producer end of the ALU's `a`/`b`/`ALUop` interface.

## Interface
- No parameters; datapath fixed at 64 bits, register index at 5 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: ID holds a real instruction this cycle.
- `stall` in 1: hold all stage outputs.
- `flush` in 1: replace the stage contents with a bubble.
- `ALUOp` in 2: main-control class. 00 = load/store, 01 = branch, 10 = R-type, 11 = I-type ALU.
- `funct3` in 3: instruction bits [14:12].
- `funct7_5` in 1: instruction bit 30.
- `rs1_data`, `rs2_data`, `imm` in 64 each: register-file reads and the sign-extended immediate.
- `alu_src` in 1: 1 selects `imm` as operand B.
- `rd_in` in 5; `reg_write_in`, `mem_read_in`, `mem_write_in`, `branch_in`, `mem_to_reg_in` in 1 each.
- `a` out 64: registered operand A, equal to `rs1_data`.
- `b` out 64: registered operand B, either `imm` or `rs2_data`.
- `alu_ctrl` out 4: registered ALU code.
- `store_data` out 64: registered `rs2_data`.
- `rd_out` out 5; `reg_write`, `mem_read`, `mem_write`, `branch`, `mem_to_reg` out 1 each.
- `valid_out` out 1: stage holds a real instruction.
- `illegal` out 1: the decode hit an unsupported funct combination.

## Operation
- **Decode (combinational, pre-register).** ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, LT 0100.
  - ALUOp 00: ADD.
  - ALUOp 01: SUB, regardless of funct3.
  - ALUOp 10, `{funct7_5, funct3}`: 0_000 → ADD, 1_000 → SUB, 0_111 → AND, 0_110 → OR, 0_010 → LT.
  - ALUOp 11, funct3 only; `funct7_5` is ignored: 000 → ADD, 111 → AND, 110 → OR, 010 → LT.
  - Any other combination: code ADD, `illegal`=1. All other fields pass through unchanged. NOR is never generated by this decode.
- **Operand B.** `alu_src` ? `imm` : `rs2_data`, full 64 bits, no truncation or extension.
- **Register update priority**, evaluated at each rising edge:
  1. `reset`: every output is cleared, with `alu_ctrl`=0010.
  2. `flush`: bubble. `valid_out`, `illegal` and all five control bits are cleared to 0; `alu_ctrl`=0010; `a`/`b`/`store_data`/`rd_out` are cleared to 0.
  3. `stall`: every output register holds its value.
  4. Otherwise the stage loads. If `valid_in`=0, it loads a bubble exactly as in case 2.
- Control bits, `illegal` and `valid_out` are written only as an ANDed set with `valid_in`. A non-valid instruction never produces `reg_write`/`mem_write`/`illegal`.
- `flush` and `stall` asserted together: flush wins.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and stay stable for the whole following cycle.
- No combinational path from inputs to outputs; every output is a flop.
- **Reset values:** `a`=`b`=`store_data`=0, `rd_out`=0, `alu_ctrl`=0010. All 1-bit outputs are 0.
- **Stall:** may last any number of cycles. Outputs stay bit-identical throughout. Inputs change freely during a stall and are not captured.
- **Release:** the first non-stall edge captures the inputs present at that edge.
- **Flush:** takes effect at the edge where it is sampled. The next cycle's inputs load normally unless `flush` or `stall` is still high.
- **Reset mid-stall or mid-flush:** reset wins on the same edge.

## Test plan
- **Reset:** hold `reset` 2 cycles with random inputs → every output 0 except `alu_ctrl`=0010; `valid_out`=0.
- **R-type sweep:** ALUOp=10, `rs1_data`=0x00000000000000F0, `rs2_data`=0x0F, `alu_src`=0. Stepping `{funct7_5, funct3}` through 0_000, 1_000, 0_111, 0_110, 0_010 gives `alu_ctrl` 0010, 0110, 0000, 0001, 0100 on consecutive cycles, `b`=0x0F each time. 0_100 gives 0010 with `illegal`=1.
- **I-type and load:** ALUOp=11, funct3=000, `funct7_5`=1, `imm`=0xFFFFFFFFFFFFFFF8, `alu_src`=1 → `alu_ctrl`=0010, `b`=0xFFFFFFFFFFFFFFF8, `illegal`=0. Then ALUOp=00 with `mem_read_in`=1 → `alu_ctrl`=0010, `mem_read`=1 one cycle later.
- **Stall hold:** load a branch (ALUOp=01, `rs1_data`=5) → `alu_ctrl`=0110, `a`=5. Assert `stall` 3 cycles while the inputs change to an R-type AND → outputs unchanged all 3 cycles. Deassert → AND (`alu_ctrl`=0000) appears one cycle later.
- **Flush with stall and valid gating:**
  - A valid store (`mem_write_in`=1) with `stall`=1 and `flush`=1 on the same edge → next cycle `valid_out`=0, `mem_write`=0, `alu_ctrl`=0010.
  - `valid_in`=0 with `reg_write_in`=1 → `reg_write`=0.
